// File: rtl/game_sequencer_if.sv
// Player-input / scoreboard bundle between the game logic and the sequencer.
// The sequencer is the slave: it consumes the event pulses and drives the status outputs.
interface game_sequencer_if;
  logic       frame_tick;
  logic       start;
  logic       brick_hit;
  logic       ball_lost;
  logic [3:0] score0;
  logic [3:0] score1;
  logic [3:0] lives;
  logic       serve;
  logic       play;
  logic       game_over;
  logic       board_show;

  modport master (
    output frame_tick, start, brick_hit, ball_lost,
    input  score0, score1, lives, serve, play, game_over, board_show
  );

  modport slave (
    input  frame_tick, start, brick_hit, ball_lost,
    output score0, score1, lives, serve, play, game_over, board_show
  );
endinterface

// File: rtl/game_sequencer.sv
// Breakout-style game flow controller: serve/play/lost/over sequencing,
// BCD score with saturation at 99, lives count and game-over scoreboard blink.
module game_sequencer #(
  parameter int START_LIVES  = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int LOST_FRAMES  = 30,
  parameter int FLASH_FRAMES = 16
) (
  input  logic             clk,
  input  logic             reset,
  game_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SERVE,
    S_PLAY,
    S_LOST,
    S_OVER
  } state_t;

  localparam int MAX_FRAMES =
    (SERVE_FRAMES > LOST_FRAMES)
      ? ((SERVE_FRAMES > FLASH_FRAMES) ? SERVE_FRAMES : FLASH_FRAMES)
      : ((LOST_FRAMES  > FLASH_FRAMES) ? LOST_FRAMES  : FLASH_FRAMES);
  localparam int TW = $clog2(MAX_FRAMES + 1);

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic          r_start_d;
  logic          r_armed;
  logic [3:0]    r_score0;
  logic [3:0]    r_score1;
  logic [3:0]    r_lives;
  logic          r_serve;
  logic          r_play;
  logic          r_over;
  logic          r_show;

  logic          w_start_edge;
  logic [TW-1:0] w_timer_next;
  logic [3:0]    w_score0_inc;
  logic [3:0]    w_score1_inc;

  // r_armed stays low after reset until start is seen low, so a button held
  // through reset release is not mistaken for a fresh press.
  assign w_start_edge = bus.start & ~r_start_d & r_armed;
  assign w_timer_next = r_timer + TW'(1);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_score0_inc = r_score0;
    w_score1_inc = r_score1;
    if (!(r_score1 == 4'd9 && r_score0 == 4'd9)) begin
      if (r_score0 == 4'd9) begin
        w_score0_inc = 4'd0;
        w_score1_inc = r_score1 + 4'd1;
      end else begin
        w_score0_inc = r_score0 + 4'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_start_d <= 1'b0;
      r_armed   <= 1'b0;
      r_score0  <= 4'd0;
      r_score1  <= 4'd0;
      r_lives   <= 4'(START_LIVES);
      r_serve   <= 1'b0;
      r_play    <= 1'b0;
      r_over    <= 1'b0;
      r_show    <= 1'b1;
    end else begin
      r_start_d <= bus.start;
      if (!bus.start) r_armed <= 1'b1;
      r_serve <= 1'b0;

      case (r_state)
        S_IDLE, S_OVER: begin
          if (w_start_edge) begin
            r_state  <= S_SERVE;
            r_score0 <= 4'd0;
            r_score1 <= 4'd0;
            r_lives  <= 4'(START_LIVES);
            r_timer  <= '0;
            r_show   <= 1'b1;
            r_over   <= 1'b0;
          end else if (r_state == S_OVER && bus.frame_tick) begin
            if (w_timer_next == TW'(FLASH_FRAMES)) begin
              r_timer <= '0;
              r_show  <= ~r_show;
            end else begin
              r_timer <= w_timer_next;
            end
          end
        end

        S_SERVE: begin
          if (bus.frame_tick) begin
            if (w_timer_next == TW'(SERVE_FRAMES)) begin
              r_state <= S_PLAY;
              r_serve <= 1'b1;
              r_play  <= 1'b1;
              r_timer <= '0;
            end else begin
              r_timer <= w_timer_next;
            end
          end
        end

        S_PLAY: begin
          if (bus.brick_hit) begin
            r_score0 <= w_score0_inc;
            r_score1 <= w_score1_inc;
          end
          if (bus.ball_lost) begin
            r_lives <= r_lives - 4'd1;
            r_play  <= 1'b0;
            r_timer <= '0;
            if (r_lives == 4'd1) begin
              r_state <= S_OVER;
              r_over  <= 1'b1;
            end else begin
              r_state <= S_LOST;
            end
          end
        end

        S_LOST: begin
          if (bus.frame_tick) begin
            if (w_timer_next == TW'(LOST_FRAMES)) begin
              r_state <= S_SERVE;
              r_timer <= '0;
            end else begin
              r_timer <= w_timer_next;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.score0     = r_score0;
  assign bus.score1     = r_score1;
  assign bus.lives      = r_lives;
  assign bus.serve      = r_serve;
  assign bus.play       = r_play;
  assign bus.game_over  = r_over;
  assign bus.board_show = r_show;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed game scenarios plus a long
// randomized run, all compared cycle by cycle against a behavioural game model.
module tb_game_sequencer;

  localparam int START_LIVES  = 3;
  localparam int SERVE_FRAMES = 60;
  localparam int LOST_FRAMES  = 30;
  localparam int FLASH_FRAMES = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  game_sequencer_if bus();

  game_sequencer #(
    .START_LIVES (START_LIVES),
    .SERVE_FRAMES(SERVE_FRAMES),
    .LOST_FRAMES (LOST_FRAMES),
    .FLASH_FRAMES(FLASH_FRAMES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: score as a plain integer, phases by name, counts of frames seen.
  typedef enum {M_IDLE, M_SERVE, M_PLAY, M_LOST, M_OVER} phase_t;
  phase_t m_phase;
  int     m_score, m_lives, m_frames, m_over_frames;
  bit     m_start_last, m_launch;

  function automatic void model_reset();
    m_phase       = M_IDLE;
    m_score       = 0;
    m_lives       = START_LIVES;
    m_frames      = 0;
    m_over_frames = 0;
    m_start_last  = 1'b1;   // a press needs start to be seen low after reset
    m_launch      = 1'b0;
  endfunction

  function automatic void model_step(bit ft, bit st, bit bh, bit bl);
    bit pressed = st && !m_start_last;
    m_start_last = st;
    m_launch     = 1'b0;
    case (m_phase)
      M_IDLE, M_OVER: begin
        if (pressed) begin
          m_phase  = M_SERVE;
          m_score  = 0;
          m_lives  = START_LIVES;
          m_frames = 0;
        end else if (m_phase == M_OVER && ft) begin
          m_over_frames++;
        end
      end
      M_SERVE: if (ft) begin
        m_frames++;
        if (m_frames >= SERVE_FRAMES) begin
          m_phase  = M_PLAY;
          m_launch = 1'b1;
          m_frames = 0;
        end
      end
      M_PLAY: begin
        if (bh) m_score = (m_score < 99) ? m_score + 1 : 99;
        if (bl) begin
          m_lives--;
          m_frames      = 0;
          m_over_frames = 0;
          m_phase       = (m_lives == 0) ? M_OVER : M_LOST;
        end
      end
      M_LOST: if (ft) begin
        m_frames++;
        if (m_frames >= LOST_FRAMES) begin
          m_phase  = M_SERVE;
          m_frames = 0;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [14:0] model_out();
    logic show;
    show = (m_phase != M_OVER) || (((m_over_frames / FLASH_FRAMES) % 2) == 0);
    return {4'(m_score / 10), 4'(m_score % 10), 4'(m_lives), m_launch,
            (m_phase == M_PLAY), (m_phase == M_OVER), show};
  endfunction

  function automatic logic [14:0] dut_out();
    return {bus.score1, bus.score0, bus.lives, bus.serve, bus.play, bus.game_over, bus.board_show};
  endfunction

  task automatic cyc(input bit ft, input bit st, input bit bh, input bit bl);
    @(negedge clk);
    bus.frame_tick = ft;
    bus.start      = st;
    bus.brick_hit  = bh;
    bus.ball_lost  = bl;
    @(posedge clk);
    model_step(ft, st, bh, bl);
    #1;
    check("cycle", 32'(dut_out()), 32'(model_out()));
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input bit st);
    @(negedge clk);
    bus.frame_tick = 1'b0;
    bus.brick_hit  = 1'b0;
    bus.ball_lost  = 1'b0;
    bus.start      = st;
    reset          = 1'b1;
    #1;
    check("reset_values", 32'(dut_out()), 32'({8'h00, 4'(START_LIVES), 4'b0001}));
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    model_step(1'b0, st, 1'b0, 1'b0);
    #1;
    check("post_reset", 32'(dut_out()), 32'(model_out()));
  endtask

  task automatic begin_game();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(SERVE_FRAMES);
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
    bus.brick_hit  = 1'b0;
    bus.ball_lost  = 1'b0;
    reset          = 1'b0;

    // Game start and one-cycle serve pulse
    do_reset(1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(SERVE_FRAMES - 1);
    check("serve_not_early", 32'(bus.serve), 32'd0);
    check("play_not_early", 32'(bus.play), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("serve_pulse", 32'(bus.serve), 32'd1);
    check("play_on", 32'(bus.play), 32'd1);
    check("lives_start", 32'(bus.lives), 32'd3);
    check("score_start", 32'({bus.score1, bus.score0}), 32'h00);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("serve_once", 32'(bus.serve), 32'd0);

    // BCD rollover and saturation
    repeat (9) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("score_09", 32'({bus.score1, bus.score0}), 32'h09);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("score_10", 32'({bus.score1, bus.score0}), 32'h10);
    repeat (95) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("score_sat_99", 32'({bus.score1, bus.score0}), 32'h99);

    // Lives down to game over
    do_reset(1'b0);
    begin_game();
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("lives_2", 32'(bus.lives), 32'd2);
    check("lost_play_off", 32'(bus.play), 32'd0);
    ticks(LOST_FRAMES);
    ticks(SERVE_FRAMES);
    check("replay_after_lost", 32'(bus.play), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("lives_1", 32'(bus.lives), 32'd1);
    ticks(LOST_FRAMES);
    ticks(SERVE_FRAMES);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("lives_0", 32'(bus.lives), 32'd0);
    check("game_over", 32'(bus.game_over), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("over_hit_ignored", 32'({bus.score1, bus.score0}), 32'h00);

    // Blink in OVER, then a held start restarts once
    ticks(FLASH_FRAMES - 1);
    check("blink_pre16", 32'(bus.board_show), 32'd1);
    ticks(1);
    check("blink_16", 32'(bus.board_show), 32'd0);
    ticks(FLASH_FRAMES - 1);
    check("blink_pre32", 32'(bus.board_show), 32'd0);
    ticks(1);
    check("blink_32", 32'(bus.board_show), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("restart_over_off", 32'(bus.game_over), 32'd0);
    check("restart_lives", 32'(bus.lives), 32'd3);
    check("restart_score", 32'({bus.score1, bus.score0}), 32'h00);
    repeat (SERVE_FRAMES) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("restart_play", 32'(bus.play), 32'd1);

    // Simultaneous brick_hit and ball_lost
    do_reset(1'b0);
    begin_game();
    repeat (5) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    ticks(LOST_FRAMES);
    ticks(SERVE_FRAMES);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check("simul_score", 32'({bus.score1, bus.score0}), 32'h06);
    check("simul_lives", 32'(bus.lives), 32'd1);
    check("simul_lost", 32'({bus.play, bus.game_over}), 32'd0);
    ticks(LOST_FRAMES - 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check("lost_ignores_events", 32'({bus.score1, bus.score0, bus.lives}), 32'h061);

    // Reset mid-SERVE with start held through it
    do_reset(1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(20);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    do_reset(1'b1);
    repeat (SERVE_FRAMES + 5) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("held_start_no_game", 32'({bus.play, bus.serve}), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    begin_game();
    check("start_after_release", 32'(bus.play), 32'd1);

    // Randomized play
    begin
      bit st = 1'b0;
      for (int i = 0; i < 20000; i++) begin
        if ($urandom_range(0, 2999) == 0) begin
          do_reset(st);
        end else begin
          if ($urandom_range(0, 39) == 0) st = ~st;
          cyc(1'($urandom_range(0, 1)), st,
              1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 39) == 0));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
